// File: rtl/sram_stream_reader_pkg.sv
// sram_stream_reader_pkg
//   Shared constants and types for the SRAM stream reader slice.
//   - Default SRAM address width, data width and word count.
//   - Reader FSM state encoding.
package sram_stream_reader_pkg;

    localparam int SRAM_ADDR_WIDTH = 4;
    localparam int SRAM_DATA_WIDTH = 8;
    localparam int SRAM_MEM_DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sram_stream_reader_fifo2.sv
// fifo2
//   Two-entry first-word-fall-through FIFO. Head entry is presented
//   combinationally from a register, so it holds stable until popped.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     i_push/i_data write request and word
//     i_pop         remove head word (ignored when empty)
//     o_data        head word
//     o_valid       FIFO not empty
//     o_count       occupancy 0..2
module fifo2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [1:0]       o_count
);

    logic [1:0][WIDTH-1:0] r_mem;
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;
    logic                  w_push;
    logic                  w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/sram_stream_reader.sv
// sram_stream_reader
//   Reads a burst of len words from a registered-output SRAM starting at
//   base_addr (wrapping at MEM_DEPTH) and streams them out over a
//   valid/ready interface, marking the final word with out_last.
//   Ports:
//     clk, rst                   clock, asynchronous active-high reset
//     start, base_addr, len      burst request (sampled in IDLE only)
//     busy, done                 burst in progress / completion pulse
//     mem_chip_en, mem_ren       SRAM enables (identical)
//     mem_raddr, mem_dout        SRAM address / data (data one cycle late)
//     out_valid, out_ready       stream handshake
//     out_data, out_last         stream word and end-of-burst flag
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int MEM_DEPTH  = SRAM_MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_chip_en,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);

    rd_state_t             r_state;
    rd_state_t             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remain;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;

    logic                  w_ren;
    logic                  w_accept;
    logic                  w_zero_start;
    logic                  w_issue_last;
    logic                  w_pop;
    logic                  w_last_hs;
    logic                  w_fifo_valid;
    logic [1:0]            w_fifo_count;
    logic [2:0]            w_pending;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_last;

    assign w_pop     = w_fifo_valid && out_ready;
    assign w_last_hs = w_pop && w_head_last;

    // Words that will still occupy the FIFO after this cycle's pop: buffered
    // plus the one coming back from last cycle's read. A new read is safe
    // only if it still fits in the two entries.
    assign w_pending = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_state_nxt  = r_state;
        w_ren        = 1'b0;
        w_accept     = 1'b0;
        w_zero_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_READ;
                    end else begin
                        w_zero_start = 1'b1;
                    end
                end
            end
            ST_READ: begin
                w_ren = (w_pending < 3'd2);
                if (w_ren && (r_remain == CNT_ONE)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_issue_last = w_ren && (r_remain == CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= w_ren;
            r_inflight_last <= w_issue_last;
            r_done          <= w_zero_start || ((r_state == ST_DRAIN) && w_last_hs);
            if (w_accept) begin
                r_addr   <= base_addr;
                r_remain <= len;
            end else if (w_ren) begin
                r_addr   <= (r_addr >= LAST_ADDR) ? '0 : r_addr + ADDR_WIDTH'(1);
                r_remain <= r_remain - CNT_ONE;
            end
        end
    end

    // SRAM data is captured only in the cycle after its read; the last flag
    // travels alongside the word through the FIFO.
    fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_last, mem_dout}),
        .i_pop   (w_pop),
        .o_data  ({w_head_last, w_head_data}),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign mem_ren     = w_ren;
    assign mem_chip_en = w_ren;
    assign mem_raddr   = r_addr;
    assign out_valid   = w_fifo_valid;
    assign out_data    = w_head_data;
    assign out_last    = w_fifo_valid && w_head_last;

endmodule

// File: tb/tb_sram_stream_reader.sv
module tb_sram_stream_reader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, mem_chip_en, mem_ren, out_valid, out_last;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_dout = '0;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    sram_stream_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_chip_en (mem_chip_en),
        .mem_ren     (mem_ren),
        .mem_raddr   (mem_raddr),
        .mem_dout    (mem_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    // SRAM model: registered read, junk on the bus when not reading.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_ren) mem_dout <= mem[mem_raddr];
        else         mem_dout <= DW'($urandom);
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        if (n_err <= 40) $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference model: expected read addresses and stream words per burst.
    logic [AW-1:0] addr_q[$];
    logic [DW:0]   word_q[$];
    int  issued = 0, accepted = 0;
    int  exp_done_cyc = -10;
    int  busy_from = 0;
    bit  burst_open = 0;
    bit  got_done = 0;
    bit  mon_en = 0;
    int  start_cyc = 0, hs_cnt = 0;
    int  first_ren_cyc = -1, first_hs_cyc = -1, last_hs_cyc = -1;
    logic [DW-1:0] first_d, last_d;
    bit  prev_stall = 0;
    logic [DW:0] prev_word;
    logic [DW:0] mw;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("chip_en", {31'b0, mem_chip_en}, {31'b0, mem_ren});
            if (mem_ren) begin
                if (first_ren_cyc < 0) first_ren_cyc = cyc;
                if (addr_q.size() == 0) fail("extra_read");
                else chk("raddr", {28'b0, mem_raddr}, {28'b0, addr_q.pop_front()});
                issued++;
            end
            if (out_valid && out_ready) begin
                if (word_q.size() == 0) fail("extra_word");
                else begin
                    mw = word_q.pop_front();
                    chk("word", {23'b0, out_data, out_last}, {23'b0, mw});
                    if (mw[0]) exp_done_cyc = cyc + 1;
                end
                if (first_hs_cyc < 0) begin first_hs_cyc = cyc; first_d = out_data; end
                last_hs_cyc = cyc;
                last_d = out_data;
                accepted++;
                hs_cnt++;
            end
            chk("pending", {31'b0, (issued - accepted) <= 2}, 32'd1);
            if (prev_stall)
                chk("stall_hold", {22'b0, out_valid, out_data, out_last}, {22'b0, 1'b1, prev_word});
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_data, out_last};
            chk("done", {31'b0, done}, {31'b0, cyc == exp_done_cyc});
            if (cyc == exp_done_cyc) begin
                chk("busy_done", {31'b0, busy}, 32'd0);
                if (busy_from <= cyc) begin got_done = 1; burst_open = 0; end
            end else begin
                chk("busy", {31'b0, busy}, {31'b0, burst_open && (cyc >= busy_from)});
            end
        end
    end

    int rdy_mode = 0;
    int rdy_idx  = 0;
    int tog[6] = '{1, 0, 0, 1, 0, 1};

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = tog[rdy_idx % 6] != 0; rdy_idx++; end
            2: out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = ($urandom_range(0, 3) == 0);
        endcase
    endtask

    // Drive start in the current cycle and load the model with the burst.
    task automatic apply_start(input int b, input int l);
        int a;
        start = 1'b1;
        base_addr = AW'(b);
        len = (AW+1)'(l);
        start_cyc = cyc; hs_cnt = 0; got_done = 0;
        first_ren_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
        busy_from = cyc + 1;
        for (int i = 0; i < l; i++) begin
            a = (b + i) % DEPTH;
            addr_q.push_back(AW'(a));
            word_q.push_back({mem[a], i == l - 1});
        end
        if (l == 0) exp_done_cyc = cyc + 1;
        else        burst_open = 1;
        step();
        start = 1'b0;
        base_addr = AW'($urandom);
        len = (AW+1)'($urandom);
    endtask

    task automatic do_start(input int b, input int l);
        step();
        apply_start(b, l);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!got_done && k < 400) begin step(); k++; end
        if (!got_done) fail("timeout_done");
    endtask

    typedef struct {
        int base; int len; int mode; int first; int last;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        tbl[0] = '{2,  4,  0, 'h12, 'h15};
        tbl[1] = '{14, 4,  0, 'h1E, 'h11};
        tbl[2] = '{0,  6,  1, 'h10, 'h15};
        tbl[3] = '{0,  0,  0, 0,    0};
        tbl[4] = '{15, 1,  2, 'h1F, 'h1F};
        tbl[5] = '{5,  16, 2, 'h15, 'h14};
        tbl[6] = '{3,  20, 0, 'h13, 'h16};
        tbl[7] = '{0,  31, 3, 'h10, 'h1E};
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 'h10);

        #2;
        chk("reset_outs", {14'b0, busy, done, mem_chip_en, mem_ren, out_valid, out_last,
                           mem_raddr, out_data}, 32'd0);
        step(); step();
        rst = 1'b0;
        mon_en = 1;
        step();

        // Table-driven bursts against fixed expectations and the model.
        foreach (tbl[i]) begin
            rdy_mode = tbl[i].mode;
            rdy_idx = 0;
            do_start(tbl[i].base, tbl[i].len);
            wait_done();
            chk("count", hs_cnt, tbl[i].len);
            if (tbl[i].len > 0) begin
                chk("first_word", {24'b0, first_d}, tbl[i].first);
                chk("last_word", {24'b0, last_d}, tbl[i].last);
            end else begin
                chk("len0_noread", first_ren_cyc, -1);
            end
            if (tbl[i].mode == 0 && tbl[i].len > 0) begin
                chk("lat_ren", first_ren_cyc - start_cyc, 1);
                chk("lat_valid", first_hs_cyc - start_cyc, 3);
                chk("throughput", last_hs_cyc - first_hs_cyc, tbl[i].len - 1);
            end
            step(); step();
        end

        // Start re-pulsed while busy is ignored; start in the done cycle is taken.
        rdy_mode = 2;
        do_start(0, 5);
        step(); step();
        start = 1'b1; base_addr = 4'd9; len = 5'd3;
        step();
        start = 1'b0;
        k = 0;
        while (cyc != exp_done_cyc && k < 400) begin step(); k++; end
        if (cyc != exp_done_cyc) fail("timeout_ignored_start");
        else begin
            chk("ign_count", hs_cnt, 5);
            chk("ign_last", {24'b0, last_d}, 'h14);
            apply_start(9, 2);
            wait_done();
            chk("redo_count", hs_cnt, 2);
            chk("redo_first", {24'b0, first_d}, 'h19);
            chk("redo_last", {24'b0, last_d}, 'h1A);
        end
        step(); step();

        // Reset after the third handshake aborts the burst with no done.
        rdy_mode = 0;
        do_start(0, 8);
        k = 0;
        while (hs_cnt < 3 && k < 100) begin step(); k++; end
        if (hs_cnt < 3) fail("timeout_third_hs");
        rst = 1'b1;
        addr_q.delete(); word_q.delete();
        burst_open = 0; issued = 0; accepted = 0; prev_stall = 0; exp_done_cyc = -10;
        #1;
        chk("midrst_outs", {14'b0, busy, done, mem_chip_en, mem_ren, out_valid, out_last,
                            mem_raddr, out_data}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        do_start(4, 2);
        wait_done();
        chk("post_rst_count", hs_cnt, 2);
        chk("post_rst_first", {24'b0, first_d}, 'h14);
        chk("post_rst_last", {24'b0, last_d}, 'h15);

        // Randomized bursts over random memory contents.
        for (int r = 0; r < 12; r++) begin
            int b, l;
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 31);
            rdy_mode = $urandom_range(0, 3);
            do_start(b, l);
            wait_done();
            chk("rand_count", hs_cnt, l);
            repeat ($urandom_range(0, 2)) step();
        end

        step(); step();
        chk("model_drained", addr_q.size() + word_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_stream_reader.md
SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL set the SRAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the SRAM and stream data width.
REQ-003 Parameter MEM_DEPTH, default 16, SHALL set the SRAM word count; addresses SHALL wrap at MEM_DEPTH.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a burst read.
REQ-007 base_addr  input  ADDR_WIDTH  first SRAM word of the burst, sampled with start.
REQ-008 len  input  ADDR_WIDTH+1  burst word count (0..2^(ADDR_WIDTH+1)-1), sampled with start.
REQ-009 busy  output  1  high while a burst is in progress.
REQ-010 done  output  1  one-cycle pulse at burst completion.
REQ-011 mem_chip_en  output  1  SRAM chip enable; equals mem_ren.
REQ-012 mem_ren  output  1  SRAM read enable.
REQ-013 mem_raddr  output  ADDR_WIDTH  SRAM read address.
REQ-014 mem_dout  input  DATA_WIDTH  SRAM registered read data, valid one cycle after mem_ren.
REQ-015 out_valid  output  1  stream word available.
REQ-016 out_ready  input  1  downstream accepts word.
REQ-017 out_data  output  DATA_WIDTH  stream word.
REQ-018 out_last  output  1  marks final word of burst; qualified by out_valid.

Function
REQ-019 FSM states IDLE, READ, DRAIN; IDLE->READ on start with len!=0; READ->DRAIN when the last read is issued; DRAIN->IDLE on the handshake of the out_last word.
REQ-020 start with len==0 in IDLE SHALL issue no reads and SHALL pulse done in the following cycle.
REQ-021 start while busy SHALL be ignored; base_addr/len changes while busy SHALL have no effect.
REQ-022 Read i (0-based) SHALL target (base_addr+i) mod MEM_DEPTH; MEM_DEPTH-1 wraps to 0.
REQ-023 Exactly len reads SHALL be issued, in address order, at most one per cycle.
REQ-024 A word SHALL be captured from mem_dout only in the cycle after its mem_ren; mem_dout is ignored otherwise.
REQ-025 Output buffering SHALL be a 2-entry FIFO; a read SHALL be issued only if occupancy + in-flight reads - (pop this cycle) < 2, so no word is ever dropped.
REQ-026 Handshake: a word transfers when out_valid && out_ready; out_valid, out_data, out_last SHALL hold stable while out_valid && !out_ready.
REQ-027 Latency: start sampled at edge E0 -> first mem_ren in cycle after E0 -> first out_valid after edge E2.
REQ-028 With out_ready held high, throughput SHALL be one word per cycle after the first.
REQ-029 out_last SHALL be high only on word len-1.
REQ-030 done SHALL pulse in the cycle after the out_last handshake; busy SHALL be low in that cycle and a new start SHALL be accepted then.
REQ-031 busy SHALL be high from the cycle after start acceptance until the done cycle, exclusive.

Reset
REQ-032 rst SHALL force IDLE, clear FIFO, in-flight flag and counters, and drive busy, done, mem_chip_en, mem_ren, out_valid, out_last to 0, mem_raddr and out_data to 0.
REQ-033 rst mid-burst SHALL abort immediately with no done pulse; the first post-reset start SHALL behave as from power-up.

Structure
REQ-034 FSM state encodings (IDLE=0, READ=1, DRAIN=2) SHALL live in the shared SRAM package alongside the default width/depth constants.
REQ-035 The 2-entry FIFO SHALL be a separate sub-module, fifo2, parameterized by DATA_WIDTH+1 (data plus last flag).

Verification
REQ-036 SRAM preloaded mem[k]=k+0x10; start base=2 len=4, out_ready=1 -> out_data 0x12,0x13,0x14,0x15 on consecutive cycles, out_last on 0x15, done one cycle later.
REQ-037 base=14 len=4 -> reads 14,15,0,1; data 0x1E,0x1F,0x10,0x11.
REQ-038 base=0 len=6, out_ready toggled 1,0,0,1,0,1... -> all six words 0x10..0x15 in order, none duplicated or lost, data stable while stalled, mem_ren never leaves more than 2 words pending.
REQ-039 start len=0 -> mem_ren never asserts, done pulses next cycle, busy stays 0.
REQ-040 start base=0 len=8; rst asserted after the third handshake -> all outputs 0 same cycle, no done; new start base=4 len=2 -> 0x14,0x15.
REQ-041 start re-pulsed with base=9 mid-burst -> ignored; original burst completes unchanged; start in done cycle accepted.
